// File: rtl/tadrrip_repl.sv
// Thread-aware DRRIP replacement engine: per-set RRPV/valid state, per-core set dueling
// with PSEL counters, and a throttled BRRIP insertion path.
module tadrrip_repl #(
  parameter int NUM_WAYS   = 16,
  parameter int NUM_SETS   = 128,
  parameter int RRPV_BITS  = 2,
  parameter int PSEL_BITS  = 10,
  parameter int NUM_CORES  = 4,
  parameter int DUEL_MOD   = 32,
  parameter int PROMOTE_FP = 0,
  localparam int SET_W  = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
  localparam int WAY_W  = $clog2(NUM_WAYS),
  localparam int CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [1:0]                     req_op,
  input  logic [SET_W-1:0]               req_set,
  input  logic [WAY_W-1:0]               req_way,
  input  logic [CORE_W-1:0]              req_core,
  output logic                           resp_valid,
  output logic [WAY_W-1:0]               resp_way,
  output logic                           resp_brrip,
  output logic [NUM_CORES*PSEL_BITS-1:0] psel_out,
  output logic [1:0]                     state_dbg
);

  // Handshake: a request is taken on any rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, so the requester holds its request until then.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_AGE    = 2'd2,
    S_FILL   = 2'd3
  } state_t;

  localparam logic [RRPV_BITS-1:0] RRPV_MAX  = '1;
  localparam logic [RRPV_BITS-1:0] RRPV_ONE  = RRPV_BITS'(1);
  localparam logic [RRPV_BITS-1:0] RRPV_LONG = RRPV_MAX - RRPV_ONE;
  localparam logic [PSEL_BITS-1:0] PSEL_MID  = {1'b1, {(PSEL_BITS-1){1'b0}}};
  localparam logic [PSEL_BITS-1:0] PSEL_SAT  = '1;
  localparam logic [PSEL_BITS-1:0] PSEL_ONE  = PSEL_BITS'(1);

  state_t state_q, state_d;

  logic [RRPV_BITS-1:0] rrpv_q  [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0]  valid_q [NUM_SETS];
  logic [PSEL_BITS-1:0] psel_q  [NUM_CORES];
  logic [4:0]           thr_q;
  logic [SET_W-1:0]     set_q;
  logic [CORE_W-1:0]    core_q;
  logic [WAY_W-1:0]     victim_q;

  logic accept;
  assign accept = req_valid & req_ready;

  // Victim search over the latched set: invalid ways take priority over distant ones.
  logic                 found_inv, found_max, search_hit;
  logic [WAY_W-1:0]     inv_way, max_way, search_way;
  logic [RRPV_BITS-1:0] set_max_rrpv, age_inc;

  always_comb begin
    found_inv    = 1'b0;
    found_max    = 1'b0;
    inv_way      = '0;
    max_way      = '0;
    set_max_rrpv = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!valid_q[set_q][w] && !found_inv) begin
        found_inv = 1'b1;
        inv_way   = WAY_W'(w);
      end
      if ((rrpv_q[set_q][w] == RRPV_MAX) && !found_max) begin
        found_max = 1'b1;
        max_way   = WAY_W'(w);
      end
      if (rrpv_q[set_q][w] > set_max_rrpv) set_max_rrpv = rrpv_q[set_q][w];
    end
    search_hit = found_inv | found_max;
    search_way = found_inv ? inv_way : max_way;
    age_inc    = RRPV_MAX - set_max_rrpv;
  end

  // Set dueling: each core owns one SRRIP and one BRRIP leader slot per DUEL_MOD sets.
  int                   duel_r;
  int                   core_i;
  logic                 core_ok, lead_s, lead_b, use_brrip;
  logic [PSEL_BITS-1:0] cur_psel;
  logic [RRPV_BITS-1:0] ins_rrpv;

  always_comb begin
    duel_r    = int'(set_q) % DUEL_MOD;
    core_i    = int'(core_q);
    core_ok   = (core_i < NUM_CORES);
    lead_s    = core_ok && (duel_r == 2 * core_i);
    lead_b    = core_ok && (duel_r == 2 * core_i + 1);
    cur_psel  = core_ok ? psel_q[core_q] : PSEL_MID;
    use_brrip = lead_b | (!lead_s & (cur_psel >= PSEL_MID));
    ins_rrpv  = (use_brrip && (thr_q != 5'd0)) ? RRPV_MAX : RRPV_LONG;
  end

  logic [RRPV_BITS-1:0] hit_old, hit_new;

  always_comb begin
    hit_old = rrpv_q[req_set][req_way];
    if (PROMOTE_FP != 0) hit_new = (hit_old == '0) ? '0 : hit_old - RRPV_ONE;
    else                 hit_new = '0;
  end

  // State register and all array updates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      thr_q    <= 5'd0;
      set_q    <= '0;
      core_q   <= '0;
      victim_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) rrpv_q[s][w] <= RRPV_MAX;
      end
      for (int c = 0; c < NUM_CORES; c++) psel_q[c] <= PSEL_MID;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            case (req_op)
              2'b00: if (valid_q[req_set][req_way]) rrpv_q[req_set][req_way] <= hit_new;
              2'b01: begin
                set_q  <= req_set;
                core_q <= req_core;
              end
              2'b10: begin
                valid_q[req_set][req_way] <= 1'b0;
                rrpv_q[req_set][req_way]  <= RRPV_MAX;
              end
              default: ;
            endcase
          end
        end
        S_SEARCH: victim_q <= search_way;
        S_AGE: begin
          // One pass lifts the oldest way to MAX, so the next search always succeeds.
          for (int w = 0; w < NUM_WAYS; w++) rrpv_q[set_q][w] <= rrpv_q[set_q][w] + age_inc;
        end
        S_FILL: begin
          rrpv_q[set_q][victim_q]  <= ins_rrpv;
          valid_q[set_q][victim_q] <= 1'b1;
          if (use_brrip) thr_q <= thr_q + 5'd1;
          if (lead_s && (psel_q[core_q] != PSEL_SAT)) psel_q[core_q] <= psel_q[core_q] + PSEL_ONE;
          if (lead_b && (psel_q[core_q] != '0))       psel_q[core_q] <= psel_q[core_q] - PSEL_ONE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept && (req_op == 2'b01)) state_d = S_SEARCH;
      S_SEARCH: state_d = search_hit ? S_FILL : S_AGE;
      S_AGE:    state_d = S_SEARCH;
      S_FILL:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_FILL);
    resp_way   = (state_q == S_FILL) ? victim_q : '0;
    resp_brrip = (state_q == S_FILL) & use_brrip;
    state_dbg  = state_q;
    for (int c = 0; c < NUM_CORES; c++) psel_out[c*PSEL_BITS +: PSEL_BITS] = psel_q[c];
  end

endmodule

// File: tb/tb_tadrrip_repl.sv
// Directed and randomized checks of tadrrip_repl against a rule-level replacement model.
module tb_tadrrip_repl;

  localparam int NW = 16;
  localparam int NS = 128;
  localparam int NC = 4;
  localparam int PB = 10;
  localparam int MAXV = 3;
  localparam int LONGV = 2;
  localparam int MID = 512;
  localparam int SAT = 1023;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic [1:0]    req_op = 2'b11;
  logic [6:0]    req_set = '0;
  logic [3:0]    req_way = '0;
  logic [1:0]    req_core = '0;
  logic          req_ready, resp_valid, resp_brrip;
  logic [3:0]    resp_way;
  logic [NC*PB-1:0] psel_out;
  logic [1:0]    state_dbg;
  logic          fp_ready, fp_resp_valid, fp_resp_brrip;
  logic [3:0]    fp_resp_way;
  logic [NC*PB-1:0] fp_psel_out;
  logic [1:0]    fp_state_dbg;

  tadrrip_repl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_set(req_set), .req_way(req_way), .req_core(req_core),
    .resp_valid(resp_valid), .resp_way(resp_way), .resp_brrip(resp_brrip),
    .psel_out(psel_out), .state_dbg(state_dbg)
  );

  tadrrip_repl #(.PROMOTE_FP(1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(fp_ready),
    .req_op(req_op), .req_set(req_set), .req_way(req_way), .req_core(req_core),
    .resp_valid(fp_resp_valid), .resp_way(fp_resp_way), .resp_brrip(fp_resp_brrip),
    .psel_out(fp_psel_out), .state_dbg(fp_state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  int errors = 0;
  int checks = 0;

  // reference model
  int m_rrpv [NS][NW];
  bit m_valid [NS][NW];
  int m_psel [NC];
  int m_thr;

  function automatic void m_reset();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) begin
        m_rrpv[s][w] = MAXV;
        m_valid[s][w] = 1'b0;
      end
    for (int c = 0; c < NC; c++) m_psel[c] = MID;
    m_thr = 0;
  endfunction

  function automatic void m_miss(input int s, input int c, output int way,
                                 output bit brrip, output int lat);
    int mx;
    int r;
    int ins;
    way = -1;
    lat = 2;
    for (int w = 0; w < NW; w++) if (way < 0 && !m_valid[s][w]) way = w;
    if (way < 0) for (int w = 0; w < NW; w++) if (way < 0 && m_rrpv[s][w] == MAXV) way = w;
    if (way < 0) begin
      lat = 4;
      mx = 0;
      for (int w = 0; w < NW; w++) if (m_rrpv[s][w] > mx) mx = m_rrpv[s][w];
      for (int w = 0; w < NW; w++) m_rrpv[s][w] += MAXV - mx;
      for (int w = 0; w < NW; w++) if (way < 0 && m_rrpv[s][w] == MAXV) way = w;
    end
    r = s % 32;
    if (r == 2 * c) begin
      brrip = 1'b0;
      if (m_psel[c] < SAT) m_psel[c]++;
    end else if (r == 2 * c + 1) begin
      brrip = 1'b1;
      if (m_psel[c] > 0) m_psel[c]--;
    end else begin
      brrip = (m_psel[c] >= MID);
    end
    ins = (brrip && m_thr != 0) ? MAXV : LONGV;
    if (brrip) m_thr = (m_thr + 1) % 32;
    m_rrpv[s][way] = ins;
    m_valid[s][way] = 1'b1;
  endfunction

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp))
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int get_psel(input int c);
    logic [PB-1:0] v;
    v = psel_out[c*PB +: PB];
    return int'(v);
  endfunction

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic drive(input logic [1:0] op, input int s, input int w, input int c);
    int guard;
    @(negedge clk);
    req_op = op;
    req_set = 7'(s);
    req_way = 4'(w);
    req_core = 2'(c);
    req_valid = 1'b1;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) chk("ready_wait", 32'(req_ready), 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op = 2'b11;
  endtask

  task automatic do_simple(input logic [1:0] op, input int s, input int w, input int c);
    drive(op, s, w, c);
    if (op == 2'b00 && m_valid[s][w]) m_rrpv[s][w] = 0;
    if (op == 2'b10) begin
      m_valid[s][w] = 1'b0;
      m_rrpv[s][w] = MAXV;
    end
    chk("simple_state", 32'(state_dbg), 0);
    chk("simple_rrpv", 32'(dut.rrpv_q[s][w]), m_rrpv[s][w]);
    chk("simple_valid", 32'(dut.valid_q[s][w]), int'(m_valid[s][w]));
  endtask

  int last_way;

  task automatic do_miss(input int s, input int c);
    int e_way;
    int e_lat;
    bit e_brrip;
    int cyc;
    m_miss(s, c, e_way, e_brrip, e_lat);
    drive(2'b01, s, $urandom_range(0, NW - 1), c);
    cyc = 0;
    while (resp_valid !== 1'b1 && cyc < 12) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("miss_latency", 32'(cyc + 1), e_lat);
    chk("miss_way", 32'(resp_way), e_way);
    chk("miss_brrip", 32'(resp_brrip), int'(e_brrip));
    chk("miss_busy_ready", 32'(req_ready), 0);
    @(posedge clk);
    #1;
    chk("fill_rrpv", 32'(dut.rrpv_q[s][e_way]), m_rrpv[s][e_way]);
    chk("fill_valid", 32'(dut.valid_q[s][e_way]), 1);
    chk("fill_psel", 32'(get_psel(c)), m_psel[c]);
    chk("fill_idle", 32'(state_dbg), 0);
    last_way = e_way;
  endtask

  int p_before [NC];
  int bad;
  int cyc;

  initial begin
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // reset state
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_way", 32'(resp_way), 0);
    chk("rst_resp_brrip", 32'(resp_brrip), 0);
    chk("rst_state", 32'(state_dbg), 0);
    for (int c = 0; c < NC; c++) chk("rst_psel", 32'(get_psel(c)), MID);

    // first BRRIP follower fill with throttle at zero
    do_miss(10, 0);
    chk("first_fill_way", 32'(last_way), 0);
    chk("first_fill_rrpv", 32'(dut.rrpv_q[10][0]), 2);

    // SRRIP leader fills a set then ages it
    for (int i = 0; i < 17; i++) do_miss(0, 0);
    chk("age_victim", 32'(last_way), 0);
    chk("age_victim_rrpv", 32'(dut.rrpv_q[0][0]), 2);
    chk("age_others", 32'(dut.rrpv_q[0][9]), 3);
    chk("srrip_psel", 32'(get_psel(0)), 529);

    // hit promotion for both promotion styles, and hit on an invalid way
    do_simple(2'b10, 0, 5, 0);
    do_miss(0, 0);
    chk("refill_way5", 32'(last_way), 5);
    chk("fp_pre_hit", 32'(dut_fp.rrpv_q[0][5]), 2);
    do_simple(2'b00, 0, 5, 0);
    chk("hit_promote_hp", 32'(dut.rrpv_q[0][5]), 0);
    chk("hit_promote_fp", 32'(dut_fp.rrpv_q[0][5]), 1);
    do_simple(2'b10, 0, 7, 0);
    do_simple(2'b00, 0, 7, 0);
    chk("hit_invalid_rrpv", 32'(dut.rrpv_q[0][7]), 3);
    do_simple(2'b11, 0, 3, 0);

    // BRRIP throttle across 33 fills
    do_reset();
    for (int i = 0; i < 33; i++) begin
      do_miss(20, 1);
      chk("throttle_rrpv", 32'(dut.rrpv_q[20][last_way]), (i == 0 || i == 32) ? 2 : 3);
    end

    // BRRIP leader drives PSEL to zero without wrapping
    for (int i = 0; i < 600; i++) do_miss(1, 0);
    chk("psel_floor", 32'(get_psel(0)), 0);
    for (int c = 0; c < NC; c++) p_before[c] = get_psel(c);
    do_miss(1, 1);
    for (int c = 0; c < NC; c++) chk("follower_psel", 32'(get_psel(c)), p_before[c]);

    // randomized mix over leader and follower sets
    for (int i = 0; i < 250; i++) begin
      int op;
      int s;
      op = $urandom_range(0, 3);
      s = $urandom_range(0, 9);
      if (op == 1) do_miss(s, $urandom_range(0, NC - 1));
      else do_simple(2'(op), s, $urandom_range(0, NW - 1), $urandom_range(0, NC - 1));
    end

    // reset in the middle of an aging pass
    do_reset();
    for (int i = 0; i < NW; i++) do_miss(40, 2);
    for (int w = 0; w < NW; w++) do_simple(2'b00, 40, w, 2);
    drive(2'b01, 40, 0, 2);
    cyc = 0;
    while (state_dbg !== 2'd2 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_age", 32'(state_dbg), 2);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_reset();
    chk("age_rst_state", 32'(state_dbg), 0);
    chk("age_rst_ready", 32'(req_ready), 1);
    chk("age_rst_resp", 32'(resp_valid), 0);
    bad = 0;
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++)
        if (dut.rrpv_q[s][w] !== 2'd3 || dut.valid_q[s][w] !== 1'b0) bad++;
    chk("age_rst_arrays", 32'(bad), 0);
    for (int c = 0; c < NC; c++) chk("age_rst_psel", 32'(get_psel(c)), MID);
    repeat (2) @(posedge clk);
    #1;
    chk("age_rst_no_fill", 32'(resp_valid), 0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tadrrip_repl.md
TADRRIP_REPL -- requirements
Module: tadrrip_repl

Interface
REQ-001 SHALL have parameter NUM_WAYS, default 16: ways per set, power of two, at least 2.
REQ-002 SHALL have parameter NUM_SETS, default 128: sets; SET_W = clog2(NUM_SETS), WAY_W = clog2(NUM_WAYS).
REQ-003 SHALL have parameter RRPV_BITS, default 2: RRPV width; MAX = 2^RRPV_BITS-1, LONG = MAX-1.
REQ-004 SHALL have parameter PSEL_BITS, default 10: width of each per-core PSEL; MID = 2^(PSEL_BITS-1).
REQ-005 SHALL have parameter NUM_CORES, default 4: requesting cores; CORE_W = max(1, clog2(NUM_CORES)).
REQ-006 SHALL have parameter DUEL_MOD, default 32: leader-set period, power of two, at least 2*NUM_CORES.
REQ-007 SHALL have parameter PROMOTE_FP, default 0: 0 = hit-priority promotion, 1 = frequency-priority promotion.
REQ-008 SHALL have one clock; reset is synchronous and active-low.
REQ-009 clk  in  1  clock; all state changes on its rising edge.
REQ-010 rst_n  in  1  synchronous active-low reset.
REQ-011 req_valid  in  1  request present.
REQ-012 req_ready  out  1  block can accept a request.
REQ-013 req_op  in  2  00 hit, 01 miss/fill, 10 invalidate, 11 no-op.
REQ-014 req_set  in  SET_W  target set.
REQ-015 req_way  in  WAY_W  way for hit or invalidate; ignored on miss.
REQ-016 req_core  in  CORE_W  requesting core.
REQ-017 resp_valid  out  1  one-cycle victim report.
REQ-018 resp_way  out  WAY_W  chosen victim way.
REQ-019 resp_brrip  out  1  1 = fill used BRRIP insertion, 0 = SRRIP.
REQ-020 psel_out  out  NUM_CORES*PSEL_BITS  PSEL values; core c at bits [c*PSEL_BITS +: PSEL_BITS].

Function
REQ-021 SHALL hold per-way RRPV and valid bit per set, one PSEL per core, and one 5-bit BRRIP throttle counter.
REQ-022 SHALL use FSM states IDLE, SEARCH, AGE, FILL; req_ready = 1 only in IDLE; acceptance = req_valid & req_ready.
REQ-023 Hit on accept: valid way gets RRPV 0 (PROMOTE_FP=0) or RRPV-1 saturating at 0 (PROMOTE_FP=1); hit on an invalid way is ignored; state stays IDLE.
REQ-024 Invalidate on accept: valid=0, RRPV=MAX; state stays IDLE. op 11 has no effect.
REQ-025 Miss on accept: latch set and core; go to SEARCH.
REQ-026 SEARCH: lowest-index invalid way if any, else lowest-index way with RRPV==MAX -> FILL; otherwise -> AGE.
REQ-027 AGE: in one cycle add (MAX - max RRPV in set) to every way of the set, then -> SEARCH.
REQ-028 FILL: resp_valid=1 and resp_way/resp_brrip driven that cycle; at its closing edge write the victim's RRPV, set its valid bit, update PSEL and throttle, -> IDLE.
REQ-029 Miss latency: resp_valid 2 cycles after the accept edge without aging, 4 cycles with one AGE pass.
REQ-030 Leader sets: r = set mod DUEL_MOD; r == 2c is SRRIP leader of core c; r == 2c+1 is BRRIP leader of core c; all other (set, core) pairs are followers.
REQ-031 Policy: SRRIP leader -> SRRIP; BRRIP leader -> BRRIP; follower of core c -> BRRIP if psel[c] >= MID, else SRRIP.
REQ-032 SRRIP insertion RRPV = LONG. BRRIP insertion RRPV = LONG when throttle==0, else MAX; throttle increments mod 32 on every BRRIP fill only.
REQ-033 PSEL: miss-fill in core c's SRRIP leader increments psel[c], saturating at 2^PSEL_BITS-1; in core c's BRRIP leader decrements psel[c], saturating at 0; exactly one update per miss; other cores unaffected.
REQ-034 Requests arriving while not in IDLE are not accepted; the requester must hold them.

Reset
REQ-035 With rst_n low at an edge: RRPV=MAX and valid=0 for all ways, psel=MID for all cores, throttle=0, state IDLE.
REQ-036 Reset outputs: req_ready=1, resp_valid=0, resp_way=0, resp_brrip=0. Reset overrides any in-flight miss; no RRPV, valid or PSEL write from that miss.

Verification
REQ-037 Reset, then miss set 10 core 0 -> resp_valid 2 cycles later, resp_way=0, resp_brrip=1, RRPV[10][0]=2 (throttle was 0).
REQ-038 17 misses to set 0, core 0 -> first 16 fill ways 0..15 at RRPV 2; 17th ages all ways to 3, resp_way=0 at 4-cycle latency, RRPV[0][0]=2, psel[0]=529.
REQ-039 Way 5 at RRPV 2, hit -> RRPV 0 (PROMOTE_FP=0); RRPV 1 (PROMOTE_FP=1); hit on an invalid way -> no change.
REQ-040 600 misses to set 1, core 0 -> psel[0] saturates at 0 with no wrap; a core-1 miss to set 1 leaves all PSELs unchanged.
REQ-041 33 consecutive BRRIP fills -> fills 1 and 33 at RRPV 2, all others at RRPV 3.
REQ-042 rst_n low during AGE -> next cycle IDLE, req_ready=1, resp_valid=0, all RRPV=3, all PSEL=512.
